// File: rtl/vram_seq.sv
// vram_seq: expands host commands into single-cycle video bus accesses.
// Define VRAM_SEQ_BOOT_CLEAR_EN to clear all of VRAM with BOOT_FILL after reset.
module vram_seq #(
  parameter int unsigned RD_LAT = 1,
  parameter logic [7:0] BOOT_FILL = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [12:0] cmd_addr,
  input  logic [12:0] cmd_len,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        done,
  output logic        busy,
  output logic        sel_ram,
  output logic        sel_ctl,
  output logic        we,
  output logic [12:0] addr,
  output logic [7:0]  din,
  input  logic [7:0]  ram_dout,
  input  logic [7:0]  ctl_dout
);
  localparam logic [1:0] OP_FILL = 2'd0;
  localparam logic [1:0] OP_CTL_WR = 2'd1;
`ifdef VRAM_SEQ_BOOT_CLEAR_EN
  typedef enum logic [2:0] {BOOT, IDLE, FILL, CTL_WR, RD_ISSUE, RD_WAIT} state_t;
  localparam state_t RST_STATE = BOOT;
  localparam logic RST_READY = 1'b0;
  logic [13:0] boot_cnt;
`else
  typedef enum logic [2:0] {IDLE, FILL, CTL_WR, RD_ISSUE, RD_WAIT} state_t;
  localparam state_t RST_STATE = IDLE;
  localparam logic RST_READY = 1'b1;
`endif
  state_t state;
  logic [12:0] rem;
  logic [1:0] lat_cnt;
  logic rd_ctl;
  assign busy = ~cmd_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST_STATE;
      cmd_ready <= RST_READY;
      sel_ram <= 1'b0;
      sel_ctl <= 1'b0;
      we <= 1'b0;
      addr <= '0;
      din <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      done <= 1'b0;
      rem <= '0;
      lat_cnt <= '0;
      rd_ctl <= 1'b0;
`ifdef VRAM_SEQ_BOOT_CLEAR_EN
      boot_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
`ifdef VRAM_SEQ_BOOT_CLEAR_EN
        BOOT: begin
          if (boot_cnt[13]) begin
            state <= IDLE;
            cmd_ready <= 1'b1;
            sel_ram <= 1'b0;
            we <= 1'b0;
          end else begin
            sel_ram <= 1'b1;
            we <= 1'b1;
            addr <= boot_cnt[12:0];
            din <= BOOT_FILL;
            boot_cnt <= boot_cnt + 14'd1;
          end
        end
`endif
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == OP_FILL && cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              // op[0] selects the control port, op[1] marks a read
              addr <= cmd_addr;
              din <= cmd_data;
              rem <= cmd_len;
              rd_ctl <= cmd_op[0];
              cmd_ready <= 1'b0;
              sel_ram <= ~cmd_op[0];
              sel_ctl <= cmd_op[0];
              we <= ~cmd_op[1];
              state <= cmd_op == OP_FILL ? FILL : cmd_op == OP_CTL_WR ? CTL_WR : RD_ISSUE;
            end
          end
        end
        FILL: begin
          rem <= rem - 13'd1;
          if (rem == 13'd1) begin
            state <= IDLE;
            cmd_ready <= 1'b1;
            done <= 1'b1;
            sel_ram <= 1'b0;
            we <= 1'b0;
          end else begin
            addr <= addr + 13'd1;
          end
        end
        CTL_WR: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
          done <= 1'b1;
          sel_ctl <= 1'b0;
          we <= 1'b0;
        end
        RD_ISSUE: begin
          state <= RD_WAIT;
          sel_ram <= 1'b0;
          sel_ctl <= 1'b0;
          lat_cnt <= 2'(RD_LAT - 1);
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            state <= IDLE;
            cmd_ready <= 1'b1;
            done <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data <= rd_ctl ? ctl_dout : ram_dout;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
          sel_ram <= 1'b0;
          sel_ctl <= 1'b0;
          we <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vram_seq.sv
// tb_vram_seq: directed table plus random commands checked cycle-by-cycle against a command-level model.
module tb_vram_seq;
  localparam int L = 1;
  localparam logic [7:0] BOOT = 8'h00;
  localparam logic [1:0] OP_FILL = 2'd0, OP_CTL_WR = 2'd1, OP_RAM_RD = 2'd2, OP_CTL_RD = 2'd3;
`ifdef VRAM_SEQ_BOOT_CLEAR_EN
  localparam logic READY0 = 1'b0;
`else
  localparam logic READY0 = 1'b1;
`endif
  typedef struct {
    logic [1:0]  op;
    logic [12:0] a;
    logic [12:0] n;
    logic [7:0]  d;
    logic [7:0]  rd;
    bit          hold;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [12:0] cmd_addr = '0, cmd_len = '0;
  logic [7:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, done, busy, sel_ram, sel_ctl, we;
  logic [7:0] rsp_data, din, ram_dout, ctl_dout;
  logic [12:0] addr;
  int total = 0, bad = 0;
  logic [7:0] exp_vram [8192] = '{default: 8'h00};
  logic [7:0] exp_ctl [8192] = '{default: 8'h00};
  logic [7:0] vmem [8192] = '{default: 8'h00};
  logic [7:0] vctl [8192] = '{default: 8'h00};
  logic [7:0] rd_d [L] = '{default: 8'h00};
  logic rd_v [L] = '{default: 1'b0};
  logic rd_c [L] = '{default: 1'b0};
  vram_seq #(.RD_LAT(L), .BOOT_FILL(BOOT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .done(done), .busy(busy), .sel_ram(sel_ram), .sel_ctl(sel_ctl),
    .we(we), .addr(addr), .din(din), .ram_dout(ram_dout), .ctl_dout(ctl_dout)
  );
  always #5 clk = ~clk;
  // video model: read data appears L cycles after the strobe, only on the addressed port
  always @(posedge clk) begin
    if (sel_ram && we) vmem[addr] <= din;
    if (sel_ctl && we) vctl[addr] <= din;
    rd_d[0] <= sel_ctl ? vctl[addr] : vmem[addr];
    rd_v[0] <= (sel_ram || sel_ctl) && !we;
    rd_c[0] <= sel_ctl;
    for (int i = 1; i < L; i++) begin
      rd_d[i] <= rd_d[i-1];
      rd_v[i] <= rd_v[i-1];
      rd_c[i] <= rd_c[i-1];
    end
  end
  assign ram_dout = (rd_v[L-1] && !rd_c[L-1]) ? rd_d[L-1] : 8'hE7;
  assign ctl_dout = (rd_v[L-1] && rd_c[L-1]) ? rd_d[L-1] : 8'h7E;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask
  function automatic logic [27:0] obs();
    return {sel_ram, sel_ctl, we, (sel_ram || sel_ctl) ? addr : 13'd0, we ? din : 8'd0, done, rsp_valid, cmd_ready, busy};
  endfunction
  function automatic logic [27:0] obs_raw();
    return {sel_ram, sel_ctl, we, addr, din, done, rsp_valid, cmd_ready, busy};
  endfunction
  localparam logic [27:0] IDLE_OBS = {3'b000, 13'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
  // expected bus/handshake snapshot k cycles after acceptance of command c
  function automatic logic [27:0] exp_obs(vec_t c, int k, int last);
    logic sr, sc, w, rdy;
    logic [12:0] ea;
    logic [7:0] ed;
    sr = 0; sc = 0; w = 0; ea = 0; ed = 0; rdy = (k == last);
    if (c.op == OP_FILL && k <= int'(c.n)) begin
      sr = 1; w = 1; ea = c.a + 13'(k - 1); ed = c.d;
    end else if (c.op == OP_CTL_WR && k == 1) begin
      sc = 1; w = 1; ea = c.a; ed = c.d;
    end else if ((c.op == OP_RAM_RD || c.op == OP_CTL_RD) && k == 1) begin
      sr = c.op == OP_RAM_RD; sc = c.op == OP_CTL_RD; ea = c.a;
    end
    return {sr, sc, w, ea, ed, rdy, (c.op == OP_RAM_RD || c.op == OP_CTL_RD) && rdy, rdy, !rdy};
  endfunction
  task automatic model_update(input vec_t c, input int cnt);
    if (c.op == OP_FILL) for (int i = 0; i < cnt; i++) exp_vram[13'(int'(c.a) + i)] = c.d;
    if (c.op == OP_CTL_WR) exp_ctl[c.a] = c.d;
  endtask
  task automatic after_reset();
`ifdef VRAM_SEQ_BOOT_CLEAR_EN
    int wr, errs, cyc;
    wr = 0; errs = 0; cyc = 0;
    while (!cmd_ready && cyc < 9000) begin
      @(negedge clk);
      cyc++;
      if (sel_ram && we) begin
        if (addr !== 13'(wr) || din !== BOOT) errs++;
        wr++;
      end
      if (sel_ctl || done || rsp_valid) errs++;
    end
    chk("boot_cycles", cyc, 8193);
    chk("boot_writes", wr, 8192);
    chk("boot_errors", errs, 0);
    for (int i = 0; i < 8192; i++) exp_vram[i] = BOOT;
`else
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_idle", obs(), IDLE_OBS);
    end
`endif
  endtask
  task automatic issue(input vec_t c, input vec_t nx, input int rst_at);
    int last, w;
    w = 0;
    while (!cmd_ready) begin
      if (w == 100) begin
        total++; bad++;
        $display("FAIL ready_wait: cmd_ready=0 after 100 cycles, want 1");
        return;
      end
      w++;
      @(negedge clk);
    end
    cmd_valid = 1; cmd_op = c.op; cmd_addr = c.a; cmd_len = c.n; cmd_data = c.d;
    last = c.op == OP_FILL ? (c.n == 0 ? 1 : int'(c.n) + 1) : c.op == OP_CTL_WR ? 2 : 2 + L;
    @(negedge clk);
    for (int k = 1; k <= last; k++) begin
      chk($sformatf("bus op=%0d a=%h k=%0d", c.op, c.a, k), obs(), exp_obs(c, k, last));
      if (k == last && (c.op == OP_RAM_RD || c.op == OP_CTL_RD)) chk($sformatf("rsp_data a=%h", c.a), rsp_data, c.rd);
      if (k == 1) begin
        if (c.hold) begin
          cmd_op = nx.op; cmd_addr = nx.a; cmd_len = nx.n; cmd_data = nx.d;
        end else begin
          cmd_valid = 0; cmd_op = 2'($urandom); cmd_addr = 13'($urandom); cmd_len = 13'($urandom); cmd_data = 8'($urandom);
        end
      end
      if (k == rst_at) begin
        reset = 1; cmd_valid = 0;
        @(negedge clk);
        chk("reset_abort", obs_raw(), {3'b000, 13'd0, 8'd0, 1'b0, 1'b0, READY0, !READY0});
        reset = 0;
        model_update(c, rst_at);
        after_reset();
        return;
      end
      if (k < last) @(negedge clk);
    end
    model_update(c, int'(c.n));
  endtask
  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end
  initial begin
    vec_t tbl [14];
    vec_t c;
    logic [12:0] last_fill;
    tbl[0]  = '{OP_FILL,   13'h0100, 13'd4, 8'hAA, 8'h00, 1'b0};
    tbl[1]  = '{OP_RAM_RD, 13'h0101, 13'd0, 8'h00, 8'hAA, 1'b0};
    tbl[2]  = '{OP_FILL,   13'h1FFE, 13'd3, 8'h55, 8'h00, 1'b0};
    tbl[3]  = '{OP_RAM_RD, 13'h0000, 13'd0, 8'h00, 8'h55, 1'b0};
    tbl[4]  = '{OP_RAM_RD, 13'h1FFD, 13'd0, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{OP_CTL_WR, 13'h0002, 13'd9, 8'h3C, 8'h00, 1'b0};
    tbl[6]  = '{OP_CTL_RD, 13'h0002, 13'd0, 8'h00, 8'h3C, 1'b0};
    tbl[7]  = '{OP_RAM_RD, 13'h0002, 13'd0, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{OP_FILL,   13'h0200, 13'd0, 8'hF0, 8'h00, 1'b0};
    tbl[9]  = '{OP_RAM_RD, 13'h0104, 13'd0, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{OP_RAM_RD, 13'h0103, 13'd0, 8'h00, 8'hAA, 1'b0};
    tbl[11] = '{OP_FILL,   13'h0300, 13'd5, 8'h11, 8'h00, 1'b1};
    tbl[12] = '{OP_CTL_WR, 13'h0005, 13'd0, 8'h77, 8'h00, 1'b0};
    tbl[13] = '{OP_CTL_RD, 13'h0005, 13'd0, 8'h00, 8'h77, 1'b0};
    @(negedge clk);
    chk("reset_state", obs_raw(), {3'b000, 13'd0, 8'd0, 1'b0, 1'b0, READY0, !READY0});
    chk("reset_rsp_data", rsp_data, 8'h00);
    @(negedge clk);
    reset = 0;
    after_reset();
    for (int i = 0; i < 14; i++) issue(tbl[i], tbl[(i + 1) % 14], 0);
    @(negedge clk);
    chk("idle_after_table", obs(), IDLE_OBS);
    last_fill = 13'h0100;
    for (int i = 0; i < 150; i++) begin
      c.op = 2'($urandom_range(0, 3));
      c.a = ($urandom_range(0, 3) == 0) ? 13'(8192 - $urandom_range(1, 8)) : 13'($urandom);
      c.n = 13'($urandom_range(0, 24));
      c.d = 8'($urandom);
      c.hold = 0;
      if (c.op == OP_RAM_RD && $urandom_range(0, 1) == 1) c.a = last_fill + 13'($urandom_range(0, 24));
      if (c.op == OP_CTL_RD && $urandom_range(0, 1) == 1) c.a = 13'($urandom_range(0, 7));
      if (c.op == OP_CTL_WR) c.a = 13'($urandom_range(0, 7));
      if (c.op == OP_FILL) last_fill = c.a;
      c.rd = c.op == OP_CTL_RD ? exp_ctl[c.a] : exp_vram[c.a];
      issue(c, c, 0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("idle_gap", obs(), IDLE_OBS);
      end
    end
    c = '{OP_FILL, 13'h0400, 13'd100, 8'h9C, 8'h00, 1'b0};
    issue(c, c, 10);
    for (int i = 0; i < 3; i++) begin
      c = '{OP_RAM_RD, 13'(13'h0408 + i), 13'd0, 8'h00, 8'h00, 1'b0};
      c.rd = exp_vram[c.a];
      issue(c, c, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
